// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with in-order load returns onto the
// register-file write port. Loads reserve a queue slot at issue, are filled on return and
// drain to the register file on cycles the ALU does not use the port.
module wb_arbiter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_LIM = 3,
   parameter int unsigned AW         = 2,
   parameter int unsigned DW         = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   input  logic [AW-1:0]       alu_wd,
   input  logic [DW-1:0]       alu_dat,
   input  logic                ld_req_valid,
   input  logic [AW-1:0]       ld_req_wd,
   input  logic                ld_rsp_valid,
   input  logic [DW-1:0]       ld_rsp_dat,
   output logic                Wen,
   output logic [AW-1:0]       Wd,
   output logic [DW-1:0]       Wdat,
   output logic [(2**AW)-1:0]  pend_mask,
   output logic                ld_stall,
   output logic                alu_hold,
   output logic                err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] FullCnt   = CW'(DEPTH);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIM);

   // Load queue storage
   logic [AW-1:0]    wd_q  [DEPTH];
   logic [DW-1:0]    dat_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] filled_q;
   logic [PW-1:0]    head_q, tail_q, fill_q;
   logic [CW-1:0]    count_q, count_d;
   logic [SW-1:0]    starve_q, starve_d;

   // Output stage; out_ld_q marks that the current write came from the load queue
   logic             wen_q;
   logic [AW-1:0]    wd_out_q;
   logic [DW-1:0]    wdat_q;
   logic             out_ld_q;
   logic             err_q, err_d;

   logic full, head_rdy, can_fill, push, fill, drain, hazard;

   // Decode this cycle's queue events from registered state only
   always_comb begin
      full     = (count_q == FullCnt);
      head_rdy = vld_q[head_q] && filled_q[head_q];
      // fill_q sits on the oldest unfilled entry, or on a free slot when none exists
      can_fill = vld_q[fill_q] && !filled_q[fill_q];
      push     = ld_req_valid && !full;
      fill     = ld_rsp_valid && can_fill;
      drain    = head_rdy && !alu_valid;
      hazard   = alu_valid && pend_mask[alu_wd];
      count_d  = count_q + CW'(push) - CW'(drain);
      err_d    = err_q | (ld_req_valid && full) | (ld_rsp_valid && !can_fill) | hazard;
      if (!head_rdy || drain) begin
         starve_d = '0;
      end else if (starve_q != StarveMax) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Pending mask: every queued load plus a load write sitting in the output stage
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (vld_q[PW'(i)]) begin
            pend_mask[wd_q[PW'(i)]] = 1'b1;
         end
      end
      if (wen_q && out_ld_q) begin
         pend_mask[wd_out_q] = 1'b1;
      end
   end

   // Queue, pointers, starvation counter, output stage and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            wd_q[PW'(i)]  <= '0;
            dat_q[PW'(i)] <= '0;
         end
         vld_q    <= '0;
         filled_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         wen_q    <= 1'b0;
         wd_out_q <= '0;
         wdat_q   <= '0;
         out_ld_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // push, fill and drain always target distinct slots
         if (push) begin
            wd_q[tail_q]     <= ld_req_wd;
            vld_q[tail_q]    <= 1'b1;
            filled_q[tail_q] <= 1'b0;
            tail_q           <= tail_q + PW'(1);
         end
         if (fill) begin
            dat_q[fill_q]    <= ld_rsp_dat;
            filled_q[fill_q] <= 1'b1;
            fill_q           <= fill_q + PW'(1);
         end
         if (drain) begin
            vld_q[head_q]    <= 1'b0;
            filled_q[head_q] <= 1'b0;
            head_q           <= head_q + PW'(1);
         end
         if (alu_valid) begin
            wen_q    <= 1'b1;
            wd_out_q <= alu_wd;
            wdat_q   <= alu_dat;
            out_ld_q <= 1'b0;
         end else if (drain) begin
            wen_q    <= 1'b1;
            wd_out_q <= wd_q[head_q];
            wdat_q   <= dat_q[head_q];
            out_ld_q <= 1'b1;
         end else begin
            wen_q    <= 1'b0;
            out_ld_q <= 1'b0;
         end
         count_q  <= count_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign Wen      = wen_q;
   assign Wd       = wd_out_q;
   assign Wdat     = wdat_q;
   assign ld_stall = full;
   assign alu_hold = (starve_q == StarveMax);
   assign err      = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked against a
// queue-based model; expected writes go to a scoreboard consumed by a separate monitor.
module tb_wb_arbiter;

   localparam int DEPTH      = 4;
   localparam int STARVE_LIM = 3;
   localparam int AW         = 2;
   localparam int DW         = 8;
   localparam int NR         = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_wd = '0;
   logic [DW-1:0] alu_dat = '0;
   logic          ld_req_valid = 1'b0;
   logic [AW-1:0] ld_req_wd = '0;
   logic          ld_rsp_valid = 1'b0;
   logic [DW-1:0] ld_rsp_dat = '0;
   logic          Wen;
   logic [AW-1:0] Wd;
   logic [DW-1:0] Wdat;
   logic [NR-1:0] pend_mask;
   logic          ld_stall;
   logic          alu_hold;
   logic          err;

   wb_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_LIM (STARVE_LIM),
      .AW         (AW),
      .DW         (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_wd       (alu_wd),
      .alu_dat      (alu_dat),
      .ld_req_valid (ld_req_valid),
      .ld_req_wd    (ld_req_wd),
      .ld_rsp_valid (ld_rsp_valid),
      .ld_rsp_dat   (ld_rsp_dat),
      .Wen          (Wen),
      .Wd           (Wd),
      .Wdat         (Wdat),
      .pend_mask    (pend_mask),
      .ld_stall     (ld_stall),
      .alu_hold     (alu_hold),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] wd;
      logic [DW-1:0] dat;
      bit            filled;
   } ld_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] wd;
      logic [DW-1:0] dat;
   } wr_t;

   // Reference model state
   ld_t           mq[$];
   wr_t           exp_q[$];
   int            m_starve = 0;
   bit            m_err = 1'b0;
   bit            m_out_ld = 1'b0;
   logic [AW-1:0] m_out_wd = '0;

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int model_pend();
      int m = 0;
      foreach (mq[i]) m |= (1 << mq[i].wd);
      if (m_out_ld) m |= (1 << m_out_wd);
      return m;
   endfunction

   function automatic bit model_has_unfilled();
      foreach (mq[i]) if (!mq[i].filled) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle: check flags against the model, drive inputs, advance the model
   task automatic step(input bit av, input int awd, input int adat,
                       input bit rq, input int rwd, input bit rs, input int rdat);
      int pm;
      int ufi;
      bit head_f;
      bit drn;
      bit was_full;
      @(negedge clk);
      pm = model_pend();
      chk("pend_mask", int'(pend_mask), pm);
      chk("ld_stall", int'(ld_stall), int'(mq.size() == DEPTH));
      chk("alu_hold", int'(alu_hold), int'(m_starve == STARVE_LIM));
      chk("err", int'(err), int'(m_err));
      alu_valid    = av;
      alu_wd       = AW'(awd);
      alu_dat      = DW'(adat);
      ld_req_valid = rq;
      ld_req_wd    = AW'(rwd);
      ld_rsp_valid = rs;
      ld_rsp_dat   = DW'(rdat);

      if (av && pm[awd]) m_err = 1'b1;
      was_full = (mq.size() == DEPTH);
      head_f   = (mq.size() > 0) && mq[0].filled;
      drn      = head_f && !av;
      if (rs) begin
         ufi = -1;
         foreach (mq[i]) if (!mq[i].filled && ufi < 0) ufi = i;
         if (ufi < 0) m_err = 1'b1;
         else begin
            mq[ufi].dat    = DW'(rdat);
            mq[ufi].filled = 1'b1;
         end
      end
      if (drn || !head_f) m_starve = 0;
      else if (m_starve < STARVE_LIM) m_starve++;
      if (av) begin
         exp_q.push_back('{cyc: cyc + 1, wd: AW'(awd), dat: DW'(adat)});
         m_out_ld = 1'b0;
      end else if (drn) begin
         exp_q.push_back('{cyc: cyc + 1, wd: mq[0].wd, dat: mq[0].dat});
         m_out_ld = 1'b1;
         m_out_wd = mq[0].wd;
      end else begin
         m_out_ld = 1'b0;
      end
      if (drn) void'(mq.pop_front());
      if (rq) begin
         if (!was_full) mq.push_back('{wd: AW'(rwd), dat: '0, filled: 1'b0});
         else m_err = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n        = 1'b0;
      alu_valid    = 1'b0;
      ld_req_valid = 1'b0;
      ld_rsp_valid = 1'b0;
      #1;
      chk("rst Wen", int'(Wen), 0);
      chk("rst pend_mask", int'(pend_mask), 0);
      chk("rst ld_stall", int'(ld_stall), 0);
      chk("rst alu_hold", int'(alu_hold), 0);
      chk("rst err", int'(err), 0);
      mq.delete();
      exp_q.delete();
      m_starve = 0;
      m_err    = 1'b0;
      m_out_ld = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: every write must match the oldest expected write for this cycle
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (Wen) begin
               if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL write: unexpected Wen Wd=%0d Wdat=0x%0h, expected no write (cycle %0d)",
                           Wd, Wdat, cyc);
               end else begin
                  w = exp_q.pop_front();
                  chk("Wd", int'(Wd), int'(w.wd));
                  chk("Wdat", int'(Wdat), int'(w.dat));
               end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               w = exp_q.pop_front();
               n_cmp++;
               n_fail++;
               $display("FAIL write: Wen=0, expected write Wd=%0d Wdat=0x%0h (cycle %0d)",
                        w.wd, w.dat, cyc);
            end
         end
      end
   end

   initial begin
      int pm;
      bit av, rq, rs;
      int awd;
      do_reset();

      // ALU only
      step(1, 2, 'h5A, 0, 0, 0, 0);
      idle(2);

      // Load issue and return
      step(0, 0, 0, 1, 1, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 1, 'hC3);
      idle(4);

      // Priority and starvation: filled head for reg 3, ALU held for several cycles
      step(0, 0, 0, 1, 3, 0, 0);
      step(1, 0, 'h11, 0, 0, 1, 'hAA);
      for (int i = 0; i < 5; i++) step(1, 0, 'h20 + i, 0, 0, 0, 0);
      idle(3);

      // Full and wrap, including a dropped 5th request
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, i, 0, 0);
      step(0, 0, 0, 1, 2, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 'h40 + i);
      idle(3);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3 - i, 1, 'h80 + i);
      idle(3);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 'h90 + i);
      idle(5);
      do_reset();

      // Response with an empty queue
      step(0, 0, 0, 0, 0, 1, 'h33);
      idle(2);
      do_reset();

      // ALU write to a register with a pending load
      step(0, 0, 0, 1, 2, 0, 0);
      step(1, 2, 'h77, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 'h66);
      idle(3);
      do_reset();

      // Reset with two filled loads queued behind a busy ALU
      step(1, 0, 'h01, 1, 1, 0, 0);
      step(1, 0, 'h02, 1, 2, 1, 'hD1);
      step(1, 0, 'h03, 0, 0, 1, 'hD2);
      do_reset();
      idle(4);

      // Randomized traffic; round 0 avoids protocol errors so err stays meaningful
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int k = 0; k < 250; k++) begin
            pm  = model_pend();
            av  = ($urandom_range(99) < 55);
            awd = int'($urandom_range(NR - 1));
            if (r == 0 && pm[awd]) av = 1'b0;
            if (mq.size() < DEPTH) rq = ($urandom_range(99) < 40);
            else rq = (r > 0) && ($urandom_range(99) < 10);
            if (model_has_unfilled()) rs = ($urandom_range(99) < 45);
            else rs = (r > 0) && ($urandom_range(99) < 5);
            step(av, awd, int'($urandom_range(255)), rq, int'($urandom_range(NR - 1)),
                 rs, int'($urandom_range(255)));
         end
         for (int k = 0; k < 3 * DEPTH; k++) begin
            rs = model_has_unfilled();
            step(0, 0, 0, 0, 0, rs, int'($urandom_range(255)));
         end
         idle(3);
         chk("writes outstanding", exp_q.size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
